// File: rtl/btn_event_bank_pkg.sv
// Shared types and helpers for the button event bank: channel FSM states and
// counter width sizing.
package btn_pkg;

    typedef enum logic [1:0] {
        BTN_RELEASED = 2'd0,
        BTN_PRESSED  = 2'd1,
        BTN_HELD     = 2'd2
    } btn_state_t;

    // Bits needed to hold values 0..n; never less than one bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/btn_event_bank_if.sv
// Button bank bus: raw levels in, debounced level and event pulses out.
interface btn_event_bank_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] dirty_in;
    logic [N_CH-1:0] clean_out;
    logic [N_CH-1:0] press_out;
    logic [N_CH-1:0] release_out;
    logic [N_CH-1:0] long_out;

    modport master (
        output dirty_in,
        input  clean_out,
        input  press_out,
        input  release_out,
        input  long_out
    );

    modport slave (
        input  dirty_in,
        output clean_out,
        output press_out,
        output release_out,
        output long_out
    );
endinterface

// File: rtl/btn_event_bank_channel.sv
// One button channel: 2-flop synchroniser, debouncer, press/hold FSM and,
// with BTN_AUTO_REPEAT_EN defined, a held-button auto-repeat counter.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic dirty_in,
    output logic clean_out,
    output logic press_out,
    output logic release_out,
    output logic long_out
);

    localparam int DEB_W  = cnt_width(DEBOUNCE_CYCLES);
    localparam int HOLD_W = cnt_width(HOLD_CYCLES);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [1:0]        sync;
    logic              s;
    logic [DEB_W-1:0]  deb_cnt;
    logic              flip;
    logic              rise_evt;
    logic              fall_evt;

    btn_state_t        state;
    btn_state_t        state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic              press_nxt;
    logic              release_nxt;
    logic              long_nxt;

`ifdef BTN_AUTO_REPEAT_EN
    localparam int RPT_W = cnt_width(REPEAT_CYCLES);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);
    logic [RPT_W-1:0]  rpt_cnt;
    logic [RPT_W-1:0]  rpt_nxt;
`endif

    assign s        = sync[1];
    assign flip     = (s != clean_out) && (deb_cnt == DEB_LAST);
    assign rise_evt = flip && s;
    assign fall_evt = flip && !s;

    // Debounced level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync      <= 2'b00;
            clean_out <= 1'b0;
            deb_cnt   <= '0;
        end else begin
            sync <= {sync[0], dirty_in};
            if (flip) begin
                clean_out <= s;
                deb_cnt   <= '0;
            end else if (s == clean_out) begin
                deb_cnt <= '0;
            end else if (deb_cnt != DEB_LAST) begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= BTN_RELEASED;
            hold_cnt    <= '0;
            press_out   <= 1'b0;
            release_out <= 1'b0;
            long_out    <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            rpt_cnt     <= '0;
`endif
        end else begin
            state       <= state_nxt;
            hold_cnt    <= hold_nxt;
            press_out   <= press_nxt;
            release_out <= release_nxt;
            long_out    <= long_nxt;
`ifdef BTN_AUTO_REPEAT_EN
            rpt_cnt     <= rpt_nxt;
`endif
        end
    end

    // A release always wins over a long-press or repeat due on the same edge.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
`ifdef BTN_AUTO_REPEAT_EN
        rpt_nxt   = rpt_cnt;
`endif
        case (state)
            BTN_RELEASED: begin
                if (rise_evt) begin
                    state_nxt = BTN_PRESSED;
                    hold_nxt  = '0;
                end
            end
            BTN_PRESSED: begin
                if (fall_evt) begin
                    state_nxt = BTN_RELEASED;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt = BTN_HELD;
`ifdef BTN_AUTO_REPEAT_EN
                    rpt_nxt   = '0;
`endif
                end else begin
                    hold_nxt = hold_cnt + 1'b1;
                end
            end
            BTN_HELD: begin
                if (fall_evt) begin
                    state_nxt = BTN_RELEASED;
`ifdef BTN_AUTO_REPEAT_EN
                    rpt_nxt   = '0;
`endif
                end else begin
`ifdef BTN_AUTO_REPEAT_EN
                    rpt_nxt = (rpt_cnt == RPT_LAST) ? '0 : rpt_cnt + 1'b1;
`endif
                end
            end
            default: state_nxt = BTN_RELEASED;
        endcase
    end

    always_comb begin
        release_nxt = fall_evt;
        long_nxt    = (state == BTN_PRESSED) && !fall_evt && (hold_cnt == HOLD_LAST);
`ifdef BTN_AUTO_REPEAT_EN
        press_nxt   = rise_evt ||
                      ((state == BTN_HELD) && !fall_evt && (rpt_cnt == RPT_LAST));
`else
        press_nxt   = rise_evt;
`endif
    end

endmodule

// File: rtl/btn_event_bank.sv
// N_CH independent button conditioners sharing one clock; auto-repeat on held
// buttons is enabled by defining BTN_AUTO_REPEAT_EN.
module btn_event_bank
    import btn_pkg::*;
#(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 50000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic            clk_in,
    input  logic            rst_in,
    btn_event_bank_if.slave bus
);

    logic [N_CH-1:0] clean_bus;
    logic [N_CH-1:0] press_bus;
    logic [N_CH-1:0] release_bus;
    logic [N_CH-1:0] long_bus;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES)
        ) u_ch (
            .clk_in      (clk_in),
            .rst_in      (rst_in),
            .dirty_in    (bus.dirty_in[g]),
            .clean_out   (clean_bus[g]),
            .press_out   (press_bus[g]),
            .release_out (release_bus[g]),
            .long_out    (long_bus[g])
        );
    end

    assign bus.clean_out   = clean_bus;
    assign bus.press_out   = press_bus;
    assign bus.release_out = release_bus;
    assign bus.long_out    = long_bus;

endmodule

// File: tb/tb_btn_event_bank.sv
// Directed bench for btn_event_bank with DEBOUNCE_CYCLES=4, HOLD_CYCLES=20,
// REPEAT_CYCLES=8; expectations follow BTN_AUTO_REPEAT_EN when defined.
module tb_btn_event_bank;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;

    btn_event_bank_if #(.N_CH(4)) bus ();

    btn_event_bank #(
        .N_CH            (4),
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (20),
        .REPEAT_CYCLES   (8)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [3:0] d);
        bus.dirty_in = d;
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int k,
                               input logic [3:0] observed, input logic [3:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s k=%0d observed=%b expected=%b", tag, k, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input int k, input logic [3:0] c,
                            input logic [3:0] p, input logic [3:0] r, input logic [3:0] l);
        checkOutput({tag, ".clean"},   k, bus.clean_out,   c);
        checkOutput({tag, ".press"},   k, bus.press_out,   p);
        checkOutput({tag, ".release"}, k, bus.release_out, r);
        checkOutput({tag, ".long"},    k, bus.long_out,    l);
    endtask

    function automatic logic [3:0] when(input bit cond, input logic [3:0] bits);
        return cond ? bits : 4'b0000;
    endfunction

    initial begin
        bit rep;
`ifdef BTN_AUTO_REPEAT_EN
        rep = 1'b1;
`else
        rep = 1'b0;
`endif
        applyStimulus(4'b0000);
        stepEdge();
        stepEdge();
        checkAll("reset", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        rst = 1'b0;

        // Clean step on ch0: accepted on the 6th edge, then released.
        applyStimulus(4'b0001);
        for (int k = 1; k <= 8; k++) begin
            stepEdge();
            checkAll("ch0_rise", k, when(k >= 6, 4'b0001), when(k == 6, 4'b0001),
                     4'b0000, 4'b0000);
        end
        applyStimulus(4'b0000);
        for (int k = 1; k <= 8; k++) begin
            stepEdge();
            checkAll("ch0_fall", k, when(k < 6, 4'b0001), 4'b0000,
                     when(k == 6, 4'b0001), 4'b0000);
        end

        // 3-cycle glitch on ch1 is rejected.
        applyStimulus(4'b0010);
        for (int k = 1; k <= 3; k++) begin
            stepEdge();
            checkAll("ch1_glitch", k, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        end
        applyStimulus(4'b0000);
        for (int k = 4; k <= 11; k++) begin
            stepEdge();
            checkAll("ch1_glitch", k, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        end

        // 4-cycle pulse on ch1 is just long enough: press at 6, release at 10.
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(when(k <= 4, 4'b0010));
            stepEdge();
            checkAll("ch1_min", k, when(k >= 6 && k <= 9, 4'b0010), when(k == 6, 4'b0010),
                     when(k == 10, 4'b0010), 4'b0000);
        end

        // Long press on ch2: press 6, long 26, repeat 34 (if enabled), release 42.
        for (int k = 1; k <= 44; k++) begin
            applyStimulus(when(k <= 36, 4'b0100));
            stepEdge();
            checkAll("ch2_long", k, when(k >= 6 && k <= 41, 4'b0100),
                     when(k == 6 || (rep && k == 34), 4'b0100),
                     when(k == 42, 4'b0100), when(k == 26, 4'b0100));
        end

        // Simultaneous ch0+ch3 press, then reset while held, then re-press.
        applyStimulus(4'b1001);
        for (int k = 1; k <= 8; k++) begin
            stepEdge();
            checkAll("ch03_press", k, when(k >= 6, 4'b1001), when(k == 6, 4'b1001),
                     4'b0000, 4'b0000);
        end
        rst = 1'b1;
        stepEdge();
        checkAll("mid_reset", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            stepEdge();
            checkAll("ch03_repress", k, when(k >= 6, 4'b1001), when(k == 6, 4'b1001),
                     4'b0000, 4'b0000);
        end
        applyStimulus(4'b0000);
        for (int k = 1; k <= 8; k++) begin
            stepEdge();
            checkAll("ch03_release", k, when(k < 6, 4'b1001), 4'b0000,
                     when(k == 6, 4'b1001), 4'b0000);
        end

        // 50-cycle hold on ch1: repeats at 34, 42, 50 only when enabled.
        for (int k = 1; k <= 58; k++) begin
            applyStimulus(when(k <= 50, 4'b0010));
            stepEdge();
            checkAll("ch1_repeat", k, when(k >= 6 && k <= 55, 4'b0010),
                     when(k == 6 || (rep && (k == 34 || k == 42 || k == 50)), 4'b0010),
                     when(k == 56, 4'b0010), when(k == 26, 4'b0010));
        end

        // ch2 release lands on the edge long would fire: long suppressed.
        for (int k = 1; k <= 30; k++) begin
            applyStimulus(when(k <= 20, 4'b0100));
            stepEdge();
            checkAll("ch2_race", k, when(k >= 6 && k <= 25, 4'b0100),
                     when(k == 6, 4'b0100), when(k == 26, 4'b0100), 4'b0000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
